// File: rtl/i2c_burst_ctrl.sv
// Burst sequencer in front of a single-byte I2C master engine: splits multi-byte
// read/write commands into per-byte engine transactions with auto-incremented word address.
module i2c_burst_ctrl #(
    parameter int LEN_W       = 4,
    parameter int WR_WAIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             sys_clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_rw_i,
    input  logic [2:0]       cmd_dev_i,
    input  logic [7:0]       cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [7:0]       wdata_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    output logic [7:0]       rdata_o,
    output logic             rdata_valid_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       dev_addr_o,
    output logic [7:0]       word_addr_o,
    output logic [7:0]       wr_data_o,
    output logic             wr_start_o,
    output logic             rd_start_o,
    input  logic [7:0]       rd_data_i,
    input  logic             i2c_busy_i,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4,
        S_CAPTURE = 3'd5,
        S_WR_WAIT = 3'd6,
        S_NEXT    = 3'd7
    } state_t;

    localparam int CNT_MAX = (TIMEOUT_CYC > WR_WAIT_CYC) ? TIMEOUT_CYC : WR_WAIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_WAIT_CYC - 1);

    state_t           state;
    logic             rw_q;
    logic [LEN_W-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;

    // Handshakes: a transfer occurs on a rising edge where valid and ready are both
    // high; ready depends only on state (never on valid), and valid outside the
    // accepting state is ignored without being consumed.
    assign cmd_ready_o   = (state == S_IDLE);
    assign wdata_ready_o = (state == S_LOAD);
    assign dbg_state_o   = state;

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            state         <= S_IDLE;
            rw_q          <= 1'b0;
            rem_q         <= '0;
            cnt_q         <= '0;
            rdata_o       <= 8'h00;
            rdata_valid_o <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            dev_addr_o    <= 3'd0;
            word_addr_o   <= 8'h00;
            wr_data_o     <= 8'h00;
            wr_start_o    <= 1'b0;
            rd_start_o    <= 1'b0;
        end else begin
            wr_start_o    <= 1'b0;
            rd_start_o    <= 1'b0;
            rdata_valid_o <= 1'b0;
            done_o        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        rw_q        <= cmd_rw_i;
                        dev_addr_o  <= cmd_dev_i;
                        word_addr_o <= cmd_addr_i;
                        rem_q       <= cmd_len_i;
                        err_o       <= 1'b0;
                        if (cmd_len_i == '0) begin
                            done_o <= 1'b1;
                        end else if (cmd_rw_i) begin
                            state <= S_START;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (wdata_valid_i) begin
                        wr_data_o <= wdata_i;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (!i2c_busy_i) begin
                        wr_start_o <= ~rw_q;
                        rd_start_o <= rw_q;
                        cnt_q      <= '0;
                        state      <= S_WAIT_HI;
                    end
                end
                // One timeout budget covers both waiting states of a byte.
                S_WAIT_HI: begin
                    if (cnt_q == TMO_LAST) begin
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (i2c_busy_i) begin
                            state <= S_WAIT_LO;
                        end
                    end
                end
                S_WAIT_LO: begin
                    if (cnt_q == TMO_LAST) begin
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end else if (!i2c_busy_i) begin
                        cnt_q <= '0;
                        state <= rw_q ? S_CAPTURE : S_WR_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    rdata_o       <= rd_data_i;
                    rdata_valid_o <= 1'b1;
                    state         <= S_NEXT;
                end
                S_WR_WAIT: begin
                    if (cnt_q == WR_LAST) begin
                        state <= S_NEXT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    rem_q       <= rem_q - 1'b1;
                    word_addr_o <= word_addr_o + 8'd1;
                    if (rem_q == LEN_W'(1)) begin
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        state <= rw_q ? S_START : S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_burst_ctrl.sv
// Bench for i2c_burst_ctrl: engine model with byte memory, scoreboard of expected
// engine transactions and read bytes, directed cases then randomized bursts.
module tb_i2c_burst_ctrl;

    localparam int LEN_W = 4;
    localparam int WR_W  = 20;
    localparam int TMO   = 200;

    logic             sys_clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic             cmd_rw_i = 1'b0;
    logic [2:0]       cmd_dev_i = 3'd0;
    logic [7:0]       cmd_addr_i = 8'h00;
    logic [LEN_W-1:0] cmd_len_i = '0;
    logic [7:0]       wdata_i = 8'h00;
    logic             wdata_valid_i = 1'b0;
    logic             wdata_ready_o;
    logic [7:0]       rdata_o;
    logic             rdata_valid_o;
    logic             done_o;
    logic             err_o;
    logic [2:0]       dev_addr_o;
    logic [7:0]       word_addr_o;
    logic [7:0]       wr_data_o;
    logic             wr_start_o;
    logic             rd_start_o;
    logic [7:0]       rd_data_i;
    logic             i2c_busy_i;
    logic [2:0]       dbg_state_o;

    always #5 sys_clk_i = ~sys_clk_i;

    i2c_burst_ctrl #(.LEN_W(LEN_W), .WR_WAIT_CYC(WR_W), .TIMEOUT_CYC(TMO)) dut (
        .sys_clk_i(sys_clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_rw_i(cmd_rw_i),
        .cmd_dev_i(cmd_dev_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .done_o(done_o), .err_o(err_o),
        .dev_addr_o(dev_addr_o), .word_addr_o(word_addr_o), .wr_data_o(wr_data_o),
        .wr_start_o(wr_start_o), .rd_start_o(rd_start_o), .rd_data_i(rd_data_i),
        .i2c_busy_i(i2c_busy_i), .dbg_state_o(dbg_state_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Device memory: seed contents shared by model and engine, ref_mem is the model's view.
    logic [7:0] seed_mem[2048];
    logic [7:0] ref_mem[2048];
    logic [7:0] eng_mem[2048];
    bit         eng_wr[2048];
    int         eng_hold = 40;
    bit         eng_stuck = 1'b0;
    int         eng_cnt;
    logic [10:0] eng_a;
    logic       eng_is_rd;

    always @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            i2c_busy_i <= 1'b0;
            rd_data_i  <= 8'h00;
            eng_cnt    <= 0;
        end else if (!i2c_busy_i && (wr_start_o || rd_start_o)) begin
            i2c_busy_i <= 1'b1;
            eng_cnt    <= eng_hold;
            eng_a      <= {dev_addr_o, word_addr_o};
            eng_is_rd  <= rd_start_o;
            rd_data_i  <= 8'($urandom);
            if (wr_start_o) begin
                eng_mem[{dev_addr_o, word_addr_o}] <= wr_data_o;
                eng_wr[{dev_addr_o, word_addr_o}]  <= 1'b1;
            end
        end else if (i2c_busy_i && !eng_stuck) begin
            if (eng_cnt <= 1) begin
                i2c_busy_i <= 1'b0;
                if (eng_is_rd) rd_data_i <= eng_wr[eng_a] ? eng_mem[eng_a] : seed_mem[eng_a];
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // Scoreboard: expected engine transactions {rd, dev, addr, wdata} and read bytes.
    logic [19:0] exp_txn_q[$];
    logic [7:0]  exp_rd_q[$];
    int   cyc = 0, start_cnt = 0, done_cnt = 0;
    int   last_start_cyc = 0, last_done_cyc = 0, fall_cyc = 0;
    bit   prev_busy = 1'b0, gap_armed = 1'b0, last_wr = 1'b0;
    logic [19:0] mon_obs;
    logic [31:0] mon_exp;

    initial forever begin
        @(negedge sys_clk_i);
        cyc++;
        if (!rst_n_i) begin
            gap_armed = 1'b0;
            last_wr   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !i2c_busy_i && last_wr) begin
                fall_cyc  = cyc;
                gap_armed = 1'b1;
            end
            prev_busy = i2c_busy_i;
            if (wr_start_o || rd_start_o) begin
                start_cnt++;
                last_start_cyc = cyc;
                check_eq("start_excl", 32'(wr_start_o & rd_start_o), 32'd0);
                if (gap_armed) begin
                    check_eq("wr_gap", 32'((cyc - fall_cyc) >= WR_W), 32'd1);
                    gap_armed = 1'b0;
                end
                mon_obs = {rd_start_o, dev_addr_o, word_addr_o, rd_start_o ? 8'h00 : wr_data_o};
                mon_exp = (exp_txn_q.size() > 0) ? 32'(exp_txn_q.pop_front()) : 32'hFFFFF;
                check_eq("txn", 32'(mon_obs), mon_exp);
                last_wr = wr_start_o;
            end
            if (rdata_valid_o) begin
                mon_exp = (exp_rd_q.size() > 0) ? 32'(exp_rd_q.pop_front()) : 32'h100;
                check_eq("rdata", 32'(rdata_o), mon_exp);
            end
            if (done_o) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (gap_armed) begin
                    check_eq("done_gap", 32'((cyc - fall_cyc) >= WR_W), 32'd1);
                    gap_armed = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        eng_stuck = 1'b0;
        cmd_valid_i = 1'b0;
        wdata_valid_i = 1'b0;
        repeat (2) @(posedge sys_clk_i);
        #1;
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_data"}, 32'({dev_addr_o, word_addr_o, wr_data_o, rdata_o}), 32'd0);
        check_eq({tag, "_flags"}, 32'({rdata_valid_o, done_o, err_o, wr_start_o, rd_start_o,
                                       wdata_ready_o, dbg_state_o}), 32'd0);
        check_eq({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
    endtask

    task automatic send_cmd(input logic rw, input logic [2:0] dev, input logic [7:0] addr,
                            input logic [3:0] len);
        bit ok = 1'b0;
        cmd_rw_i = rw; cmd_dev_i = dev; cmd_addr_i = addr; cmd_len_i = len;
        cmd_valid_i = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (cmd_ready_o) begin
                @(posedge sys_clk_i);
                #1;
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        cmd_valid_i = 1'b0;
        check_eq("cmd_accept", 32'(ok), 32'd1);
        tick();
        check_eq("err_clear", 32'(err_o), 32'd0);
    endtask

    task automatic run_cmd(input logic rw, input logic [2:0] dev, input logic [7:0] addr,
                           input logic [3:0] len, input logic [127:0] data,
                           input int stall0, input int hold, input bit tmo);
        logic [7:0] a;
        int snap_d, snap_s, bound;
        bit got;
        eng_hold = hold;
        eng_stuck = tmo;
        for (int i = 0; i < int'(len); i++) begin
            a = addr + 8'(i);
            if (!tmo || i == 0) exp_txn_q.push_back({rw, dev, a, rw ? 8'h00 : data[8*i +: 8]});
            if (!tmo) begin
                if (rw) exp_rd_q.push_back(ref_mem[{dev, a}]);
                else ref_mem[{dev, a}] = data[8*i +: 8];
            end
        end
        snap_d = done_cnt;
        send_cmd(rw, dev, addr, len);
        if (len == 4'd0) begin
            check_eq("len0_done", 32'(done_o), 32'd1);
            check_eq("len0_ready", 32'(cmd_ready_o), 32'd1);
        end
        if (!rw) begin
            for (int i = 0; i < int'(len); i++) begin
                if (i == 0 && stall0 > 0) begin
                    snap_s = start_cnt;
                    repeat (stall0) tick();
                    check_eq("stall_no_start", 32'(start_cnt), 32'(snap_s));
                end
                wdata_i = data[8*i +: 8];
                wdata_valid_i = 1'b1;
                got = 1'b0;
                for (int k = 0; k < 2000 && !got; k++) begin
                    if (wdata_ready_o) begin
                        @(posedge sys_clk_i);
                        #1;
                        got = 1'b1;
                    end else begin
                        tick();
                    end
                end
                wdata_valid_i = 1'b0;
                wdata_i = 8'($urandom);
                check_eq("wdata_taken", 32'(got), 32'd1);
            end
        end
        bound = int'(len) * (hold + WR_W + 20) + TMO + 100;
        for (int k = 0; k < bound && done_cnt == snap_d; k++) tick();
        check_eq("done_seen", 32'(done_cnt != snap_d), 32'd1);
        check_eq("err_flag", 32'(err_o), 32'(tmo));
        repeat (5) tick();
        check_eq("one_done", 32'(done_cnt), 32'(snap_d + 1));
        check_eq("ready_idle", 32'(cmd_ready_o), 32'd1);
        check_eq("txn_left", 32'(exp_txn_q.size()), 32'd0);
        check_eq("rd_left", 32'(exp_rd_q.size()), 32'd0);
        if (tmo) begin
            check_eq("tmo_window", 32'((last_done_cyc - last_start_cyc) >= TMO - 5 &&
                                       (last_done_cyc - last_start_cyc) <= TMO + 5), 32'd1);
        end
        exp_txn_q.delete();
        exp_rd_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int snap_s, snap_d;
        logic [3:0] rlen;
        logic [7:0] raddr;
        for (int i = 0; i < 2048; i++) begin
            seed_mem[i] = 8'($urandom);
            ref_mem[i] = seed_mem[i];
        end
        seed_mem[{3'd0, 8'hFE}] = 8'h11; ref_mem[{3'd0, 8'hFE}] = 8'h11;
        seed_mem[{3'd0, 8'hFF}] = 8'h22; ref_mem[{3'd0, 8'hFF}] = 8'h22;
        seed_mem[{3'd0, 8'h00}] = 8'h33; ref_mem[{3'd0, 8'h00}] = 8'h33;
        do_reset();
        check_idle_outputs("reset");

        run_cmd(1'b0, 3'd0, 8'h10, 4'd3, {104'h0, 8'hFF, 8'h5A, 8'hA5}, 0, 40, 1'b0);
        run_cmd(1'b1, 3'd0, 8'hFE, 4'd3, 128'h0, 0, 40, 1'b0);
        run_cmd(1'b0, 3'd1, 8'h80, 4'd2, {$urandom, $urandom, $urandom, $urandom}, 50, 25, 1'b0);
        run_cmd(1'b0, 3'd2, 8'h00, 4'd0, 128'h0, 0, 10, 1'b0);
        run_cmd(1'b1, 3'd4, 8'h33, 4'd0, 128'h0, 0, 10, 1'b0);

        run_cmd(1'b1, 3'd5, 8'h20, 4'd2, 128'h0, 0, 10, 1'b1);
        repeat (20) tick();
        check_eq("err_sticky", 32'(err_o), 32'd1);
        run_cmd(1'b0, 3'd5, 8'h00, 4'd0, 128'h0, 0, 10, 1'b0);
        do_reset();

        // Abort a read burst in the middle of its second byte.
        eng_hold = 40;
        snap_s = start_cnt;
        snap_d = done_cnt;
        exp_txn_q.push_back({1'b1, 3'd2, 8'h40, 8'h00});
        exp_txn_q.push_back({1'b1, 3'd2, 8'h41, 8'h00});
        exp_rd_q.push_back(ref_mem[{3'd2, 8'h40}]);
        send_cmd(1'b1, 3'd2, 8'h40, 4'd4);
        for (int k = 0; k < 400 && start_cnt < snap_s + 2; k++) tick();
        repeat (10) tick();
        rst_n_i = 1'b0;
        @(posedge sys_clk_i);
        #1;
        rst_n_i = 1'b1;
        tick();
        check_idle_outputs("mid_reset");
        repeat (300) tick();
        check_eq("rst_starts", 32'(start_cnt), 32'(snap_s + 2));
        check_eq("rst_no_done", 32'(done_cnt), 32'(snap_d));
        check_eq("rst_txn_left", 32'(exp_txn_q.size()), 32'd0);
        check_eq("rst_rd_left", 32'(exp_rd_q.size()), 32'd0);
        exp_txn_q.delete();
        exp_rd_q.delete();

        for (int n = 0; n < 14; n++) begin
            rlen = 4'($urandom_range(0, 15));
            raddr = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'hF4, 8'hFF)) : 8'($urandom);
            run_cmd(1'($urandom_range(0, 1)), 3'($urandom), raddr, rlen,
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 5), $urandom_range(2, 30), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
